// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX-stage control and the RV32M sequencer.
interface muldiv_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            Start;
    logic            Flush;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] OpA;
    logic [XLEN-1:0] OpB;
    logic [XLEN-1:0] Result;
    logic            Busy;
    logic            Done;
    logic            Stall;

    modport master (
        output Start, Flush, Funct3, OpA, OpB,
        input  Result, Busy, Done, Stall
    );

    modport slave (
        input  Start, Flush, Funct3, OpA, OpB,
        output Result, Busy, Done, Stall
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// XLEN iterations plus one sign-correction cycle, with a fast path for div-by-zero/overflow.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input logic               clk,
    input logic               rst,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned CntW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFinish, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [XLEN:0]     acc_q, acc_d;   // product high half / partial remainder
    logic [XLEN-1:0]   lo_q, lo_d;     // product low half / dividend shifting into quotient
    logic [XLEN-1:0]   opb_q, opb_d;   // multiplicand / divisor magnitude
    logic [XLEN-1:0]   result_q, result_d;

    logic              idle_like, accept;
    logic              a_signed, b_signed, sa, sb, b_zero, ovf;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     msum, shifted, diff;
    logic              ge;
    logic [2*XLEN-1:0] prod, prod_s;
    logic              neg_res;
    logic [XLEN-1:0]   quo_s, rem_s, res_sel;

    assign idle_like = (state_q == StIdle) || (state_q == StDone);
    assign accept    = bus.Start && idle_like && !bus.Flush;

    assign a_signed = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b010) ||
                      (bus.Funct3[2] && !bus.Funct3[0]);
    assign b_signed = (bus.Funct3 == 3'b001) || (bus.Funct3[2] && !bus.Funct3[0]);
    assign sa       = a_signed && bus.OpA[XLEN-1];
    assign sb       = b_signed && bus.OpB[XLEN-1];
    assign abs_a    = sa ? -bus.OpA : bus.OpA;
    assign abs_b    = sb ? -bus.OpB : bus.OpB;
    assign b_zero   = (bus.OpB == '0);
    assign ovf      = bus.Funct3[2] && !bus.Funct3[0] &&
                      (bus.OpA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.OpB == '1);

    // One shift-add or restoring-subtract step.
    assign msum    = {1'b0, acc_q[XLEN-1:0]} + (lo_q[0] ? {1'b0, opb_q} : '0);
    assign shifted = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, opb_q};
    assign ge      = (shifted >= {1'b0, opb_q});

    // Sign correction; flags are zero for unsigned forms so they pass through.
    assign neg_res = sign_a_q ^ sign_b_q;
    assign prod    = {acc_q[XLEN-1:0], lo_q};
    assign prod_s  = neg_res ? -prod : prod;
    assign quo_s   = neg_res ? -lo_q : lo_q;
    assign rem_s   = sign_a_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

    always_comb begin
        res_sel = quo_s;
        unique case (f3_q)
            3'b000:                 res_sel = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res_sel = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res_sel = quo_s;
            3'b110, 3'b111:         res_sel = rem_s;
            default:                res_sel = quo_s;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        result_d = result_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    f3_d     = bus.Funct3;
                    sign_a_d = sa;
                    sign_b_d = sb;
                    acc_d    = '0;
                    lo_d     = abs_a;
                    opb_d    = abs_b;
                    cnt_d    = '0;
                    if (bus.Funct3[2] && b_zero) begin
                        result_d = bus.Funct3[1] ? bus.OpA : '1;
                        state_d  = StDone;
                    end else if (ovf) begin
                        result_d = bus.Funct3[1] ? '0 : bus.OpA;
                        state_d  = StDone;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (f3_q[2]) begin
                    acc_d = ge ? diff : shifted;
                    lo_d  = {lo_q[XLEN-2:0], ge};
                end else begin
                    acc_d = {1'b0, msum[XLEN:1]};
                    lo_d  = {msum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(XLEN - 1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                result_d = res_sel;
                state_d  = StDone;
            end
            default: state_d = StIdle;
        endcase

        // An aborted operation never lands in Result.
        if (bus.Flush) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            f3_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

    assign bus.Result = result_q;
    assign bus.Busy   = (state_q == StRun) || (state_q == StFinish);
    assign bus.Done   = (state_q == StDone);
    assign bus.Stall  = accept || bus.Busy;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against a plain-arithmetic RV32M model.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] last_result = '0;

    muldiv_sequencer_if #(.XLEN(32)) bus ();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        logic [63:0]     t;
        int              ia, ib, iq;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        case (f3)
            3'b000: begin up = ua * ub; t = up; return t[31:0]; end
            3'b001: begin p = sa * sb; t = p; return t[63:32]; end
            3'b010: begin p = sa * longint'(ub); t = p; return t[63:32]; end
            3'b011: begin up = ua * ub; t = up; return t[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                iq = ia / ib;
                return iq;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                iq = ia % ib;
                return iq;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Drive a request in the current cycle; Stall must rise combinationally.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.Start  = 1'b1;
        bus.Funct3 = f3;
        bus.OpA    = a;
        bus.OpB    = b;
        #1;
        check("stall_on_accept", bus.Stall, 1);
    endtask

    // Returns during the Done cycle (at its falling edge) so a caller may chain a Start.
    task automatic wait_done(input logic [31:0] exp_res, input int exp_cyc, input int poke_cyc);
        int c = 1;
        int stall_bad = 0;
        bit seen = 0;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        while (!seen && c <= exp_cyc + 3) begin
            if (c == poke_cyc) begin
                bus.Start  = 1'b1;
                bus.Funct3 = 3'b100;
                bus.OpA    = $urandom;
                bus.OpB    = 32'd0;
            end else if (c == poke_cyc + 1) begin
                bus.Start = 1'b0;
            end
            @(negedge clk);
            if (bus.Done) begin
                seen = 1;
            end else begin
                if (bus.Stall !== 1'b1) stall_bad++;
                @(posedge clk);
                #1;
                c++;
            end
        end
        check("done_seen", seen, 1);
        check("done_cycle", c, exp_cyc);
        check("result", bus.Result, exp_res);
        check("stall_busy_in_run", stall_bad, 0);
        check("done_stall_busy", {bus.Stall, bus.Busy}, 2'b00);
        last_result = exp_res;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        check("done_one_cycle", bus.Done, 0);
        check("result_held", bus.Result, last_result);
    endtask

    task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        issue(f3, a, b);
        wait_done(model(f3, a, b), latency(f3, a, b), 0);
    endtask

    task automatic no_done_window(input string tag);
        int seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.Done) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        rst        = 1'b1;
        bus.Start  = 1'b0;
        bus.Flush  = 1'b0;
        bus.Funct3 = '0;
        bus.OpA    = '0;
        bus.OpB    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {bus.Result, bus.Busy, bus.Done, bus.Stall}, 35'd0);
        rst = 1'b0;

        // Directed cases from the expected-value table.
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_done(32'hFFFF_FFEB, 34, 0);
        idle_cycle();
        run(3'b001, 32'h8000_0000, 32'h8000_0000);
        check("mulh_min", last_result, 32'h4000_0000);
        idle_cycle();
        run(3'b011, 32'h8000_0000, 32'h8000_0000);
        idle_cycle();
        run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulhsu_m1", last_result, 32'hFFFF_FFFF);
        idle_cycle();

        // Back-to-back divides, each started in the previous Done cycle.
        issue(3'b100, -32'sd7, 32'd2);
        wait_done(32'hFFFF_FFFD, 34, 0);
        issue(3'b110, -32'sd7, 32'd2);
        wait_done(32'hFFFF_FFFF, 34, 0);
        issue(3'b101, 32'd100, 32'd7);
        wait_done(32'd14, 34, 0);
        issue(3'b111, 32'd100, 32'd7);
        wait_done(32'd2, 34, 0);
        idle_cycle();

        // Fast-path cases.
        issue(3'b101, 32'd5, 32'd0);
        wait_done(32'hFFFF_FFFF, 1, 0);
        idle_cycle();
        issue(3'b111, 32'd5, 32'd0);
        wait_done(32'd5, 1, 0);
        idle_cycle();
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(32'h8000_0000, 1, 0);
        idle_cycle();
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(32'd0, 1, 0);
        idle_cycle();

        // Start while busy must be ignored.
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_done(32'hFFFF_FFEB, 34, 5);
        idle_cycle();

        // Randomized operations, randomly chained back-to-back.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run(f3, a, b);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();

        // Flush together with Start in IDLE: not accepted.
        bus.Start  = 1'b1;
        bus.Flush  = 1'b1;
        bus.Funct3 = 3'b000;
        #1;
        check("flush_start_stall", bus.Stall, 0);
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        check("flush_start_busy", bus.Busy, 0);

        // Flush mid-divide.
        issue(3'b100, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        bus.Start = 1'b0;
        bus.Flush = 1'b1;
        @(posedge clk);
        #1;
        bus.Flush = 1'b0;
        check("flush_busy_stall", {bus.Busy, bus.Stall}, 2'b00);
        check("flush_result_kept", bus.Result, last_result);
        no_done_window("flush_no_done");

        // Reset mid-divide.
        issue(3'b100, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        bus.Start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_result", bus.Result, 0);
        check("rst_busy_done", {bus.Busy, bus.Done, bus.Stall}, 3'b000);
        no_done_window("rst_no_done");
        last_result = '0;

        run(3'b001, -32'sd3, 32'd5);
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
